// File: rtl/guess_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : guess_input_ctrl (with helper guess_input_ctrl_deb)
// Description : Button/switch front end of the guessing game. It produces
//               start/new-number pulses and a valid/ready guess, and it
//               counts the attempts in each round.
//               Define SW_DEBOUNCE_EN to debounce the switch groups as well.
// Revision    : 1.0 - initial release
// ============================================================================

module guess_input_ctrl_deb #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIDTH           = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sync,
    output logic [WIDTH-1:0] o_stable
);
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_stable;

    // The whole group shares one counter. Any disagreement keeps it running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (i_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_stable <= i_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_stable = r_stable;
endmodule

module guess_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GUESS_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnC,
    input  logic               btnU,
    input  logic [15:0]        sw,
    output logic               start_pulse,
    output logic               new_num_pulse,
    output logic               started,
    output logic [GUESS_W-1:0] guess_data,
    output logic               guess_valid,
    input  logic               guess_ready,
    output logic [7:0]         attempt_cnt
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [1:0]         r_btn_s1, r_btn_s2;
    logic [15:0]        r_sw_s1, r_sw_s2;
    logic [1:0]         w_btn_stable;
    logic [1:0]         r_btn_stable_d;
    logic [1:0]         r_rise;
    logic               w_sw_en;
    logic [GUESS_W-1:0] w_sw_guess;
    logic [1:0]         r_state;
    logic               r_started;
    logic               r_valid;
    logic [GUESS_W-1:0] r_data;
    logic [7:0]         r_attempt;
    logic               w_handshake;
    logic               w_new_num;

    // Bit 0 is btnC and bit 1 is btnU.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1       <= '0;
            r_btn_s2       <= '0;
            r_sw_s1        <= '0;
            r_sw_s2        <= '0;
            r_btn_stable_d <= '0;
            r_rise         <= '0;
        end else begin
            r_btn_s1       <= {btnU, btnC};
            r_btn_s2       <= r_btn_s1;
            r_sw_s1        <= sw;
            r_sw_s2        <= r_sw_s1;
            r_btn_stable_d <= w_btn_stable;
            r_rise         <= w_btn_stable & ~r_btn_stable_d;
        end
    end

    guess_input_ctrl_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_deb_c (
        .clk(clk), .rst(rst), .i_sync(r_btn_s2[0]), .o_stable(w_btn_stable[0])
    );
    guess_input_ctrl_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_deb_u (
        .clk(clk), .rst(rst), .i_sync(r_btn_s2[1]), .o_stable(w_btn_stable[1])
    );

`ifdef SW_DEBOUNCE_EN
    guess_input_ctrl_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(1)) u_deb_sw_en (
        .clk(clk), .rst(rst), .i_sync(r_sw_s2[0]), .o_stable(w_sw_en)
    );
    guess_input_ctrl_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WIDTH(GUESS_W)) u_deb_sw_val (
        .clk(clk), .rst(rst), .i_sync(r_sw_s2[15:16-GUESS_W]), .o_stable(w_sw_guess)
    );
`else
    assign w_sw_en    = r_sw_s2[0];
    assign w_sw_guess = r_sw_s2[15:16-GUESS_W];
`endif

    generate
        if (GUESS_W < 15) begin : g_unused_sw
            logic w_unused_sw;
            assign w_unused_sw = ^r_sw_s2[15-GUESS_W:1];
        end
    endgenerate

    assign w_handshake = r_valid & guess_ready;
    assign w_new_num   = r_rise[1] & r_started;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_started <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_rise[0]) begin
                        r_started <= 1'b1;
                        r_state   <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    if (r_rise[0] && w_sw_en) begin
                        r_data  <= w_sw_guess;
                        r_valid <= 1'b1;
                        r_state <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    // Presses made while a guess is pending are dropped.
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_state <= c_ST_ARMED;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // A new number clears the count even if a handshake lands on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_attempt <= '0;
        end else if (w_new_num) begin
            r_attempt <= '0;
        end else if (w_handshake && (r_attempt != 8'hFF)) begin
            r_attempt <= r_attempt + 8'd1;
        end
    end

    assign start_pulse   = r_rise[0] & (r_state == c_ST_IDLE);
    assign new_num_pulse = w_new_num;
    assign started       = r_started;
    assign guess_data    = r_data;
    assign guess_valid   = r_valid;
    assign attempt_cnt   = r_attempt;
endmodule

`default_nettype wire

// File: tb/tb_guess_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_input_ctrl
// Description : Directed bench for guess_input_ctrl with DEBOUNCE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_guess_input_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        btnC, btnU;
    logic [15:0] sw;
    logic        start_pulse, new_num_pulse, started;
    logic [7:0]  guess_data;
    logic        guess_valid, guess_ready;
    logic [7:0]  attempt_cnt;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_new = 0;

    guess_input_ctrl #(.DEBOUNCE_CYCLES(4), .GUESS_W(8)) dut (
        .clk(clk), .rst(rst), .btnC(btnC), .btnU(btnU), .sw(sw),
        .start_pulse(start_pulse), .new_num_pulse(new_num_pulse),
        .started(started), .guess_data(guess_data), .guess_valid(guess_valid),
        .guess_ready(guess_ready), .attempt_cnt(attempt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on falling edges only.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_start += int'(start_pulse);
            n_new   += int'(new_num_pulse);
        end
    endtask

    task automatic press(input logic c, input logic u, input int hold);
        btnC = c;
        btnU = u;
        run(hold);
        btnC = 1'b0;
        btnU = 1'b0;
        run(12);
    endtask

    initial begin
        int s0, n0, idx, cnt;
        rst = 1'b1; btnC = 1'b0; btnU = 1'b0; sw = 16'h0; guess_ready = 1'b0;
        run(3);
        check("reset_outputs", {started, guess_valid, start_pulse, new_num_pulse}, 0);
        check("reset_attempt", attempt_cnt, 0);
        check("reset_data", guess_data, 0);
        rst = 1'b0;
        run(2);

        // Start press: the pulse must land on the 7th edge after the raw rise.
        btnC = 1'b1; cnt = 0; idx = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (start_pulse) begin cnt++; idx = i; end
        end
        check("start_pulse_count", cnt, 1);
        check("start_pulse_edge", idx, 7);
        btnC = 1'b0;
        run(12);
        check("started_high", started, 1);
        check("valid_after_start", guess_valid, 0);

        n0 = n_new;
        press(1'b0, 1'b1, 3);
        check("btnU_glitch_no_pulse", n_new - n0, 0);
        n0 = n_new;
        press(1'b0, 1'b1, 10);
        check("btnU_one_pulse", n_new - n0, 1);
        check("attempt_after_newnum", attempt_cnt, 0);

        // Ready while no guess is pending must be ignored.
        sw = 16'hA501; guess_ready = 1'b1;
        run(3);
        guess_ready = 1'b0;
        check("ready_without_valid", attempt_cnt, 0);
        btnC = 1'b1;
        run(7);
        check("valid_at_rise", guess_valid, 0);
        run(1);
        check("valid_one_after_rise", guess_valid, 1);
        check("data_captured", guess_data, 8'hA5);
        run(2);
        btnC = 1'b0;
        run(12);
        check("valid_held", guess_valid, 1);
        check("data_held", guess_data, 8'hA5);
        sw = 16'h1201;
        press(1'b1, 1'b0, 10);
        check("hold_press_dropped_valid", guess_valid, 1);
        check("hold_press_dropped_data", guess_data, 8'hA5);
        check("hold_attempt", attempt_cnt, 0);
        guess_ready = 1'b1;
        run(1);
        guess_ready = 1'b0;
        check("handshake_valid_low", guess_valid, 0);
        check("handshake_attempt", attempt_cnt, 1);

        sw = 16'h3C00;
        run(3);
        press(1'b1, 1'b0, 10);
        check("disabled_no_valid", guess_valid, 0);
        check("disabled_attempt", attempt_cnt, 1);

        // 257 submissions with ready tied high: 1 + 257 saturates at 255.
        sw = 16'h5501; guess_ready = 1'b1;
        run(3);
        for (int k = 0; k < 257; k++) press(1'b1, 1'b0, 10);
        check("attempt_saturated", attempt_cnt, 255);

        // btnU one cycle after btnC puts new_num_pulse on the handshake cycle.
        btnC = 1'b1;
        run(1);
        btnU = 1'b1;
        run(7);
        check("coincide_valid", guess_valid, 1);
        check("coincide_newnum", new_num_pulse, 1);
        run(1);
        check("clear_wins", attempt_cnt, 0);
        check("coincide_valid_low", guess_valid, 0);
        btnC = 1'b0; btnU = 1'b0;
        run(12);

        // Leave a nonzero count and a pending guess, then reset.
        press(1'b1, 1'b0, 10);
        check("pre_reset_attempt", attempt_cnt, 1);
        guess_ready = 1'b0; sw = 16'hA501;
        run(3);
        press(1'b1, 1'b0, 10);
        check("pre_reset_valid", guess_valid, 1);
        rst = 1'b1;
        run(1);
        check("rst_hold_flags", {started, guess_valid, start_pulse, new_num_pulse}, 0);
        check("rst_hold_attempt", attempt_cnt, 0);
        check("rst_hold_data", guess_data, 0);
        rst = 1'b0;
        run(2);
        n0 = n_new;
        press(1'b0, 1'b1, 10);
        check("btnU_before_start", n_new - n0, 0);
        check("still_not_started", started, 0);
        s0 = n_start;
        press(1'b1, 1'b0, 10);
        check("restart_pulse", n_start - s0, 1);
        check("restarted", started, 1);
        n0 = n_new;
        press(1'b0, 1'b1, 10);
        check("btnU_after_restart", n_new - n0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/guess_input_ctrl.md
Name: guess_input_ctrl

Overview:
- Input-side front end for the number-guessing game on the Basys3 board, opposite to the display/LED output path.
- Synchronizes and debounces btnC/btnU, synchronizes the switch bank, and produces clean single-cycle control pulses.
- Captures sw[15:8] as a guess and delivers it to the game core over a valid/ready handshake.
- Maintains a per-round attempt counter.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synced button must differ from its stable value before the stable value updates (5 ms at 100 MHz); legal range 2..2^20.
- GUESS_W, 8: guess width; taken from sw[15:16-GUESS_W].

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- btnC  input  1  raw centre button; first press starts, later presses submit guesses
- btnU  input  1  raw up button; requests a new secret number
- sw  input  16  raw switches; sw[0] = guess-enable, sw[15:8] = guess value
- start_pulse  output  1  one-cycle pulse on the press that starts the game
- new_num_pulse  output  1  one-cycle pulse per debounced btnU press, only after start
- started  output  1  high from start press until reset
- guess_data  output  GUESS_W  captured guess, stable while guess_valid=1
- guess_valid  output  1  guess available
- guess_ready  input  1  game core accepts guess when valid&ready
- attempt_cnt  output  8  accepted guesses this round, saturating

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, FSM=IDLE, synchronizers/stable values/debounce counters 0.
- Synchronizer:
  - 2-flop synchronizer on btnC, btnU, and sw[15:0].
  - "synced" values are 2 edges behind the raw inputs.
- Debounce, per button:
  - Counter increments while synced != stable and clears to 0 when synced == stable.
  - When the counter reaches DEBOUNCE_CYCLES-1 with synced still differing, stable <= synced and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect:
  - rise = stable & ~stable_d (registered).
  - A raw press held long enough gives rise exactly DEBOUNCE_CYCLES+3 edges after the raw 0->1.
  - Release is filtered symmetrically and produces no pulse.
- FSM states IDLE, ARMED, HOLD:
  - IDLE: btnC rise -> start_pulse=1 for one cycle, started<=1, go ARMED. btnU rise ignored; new_num_pulse stays 0.
  - ARMED: btnC rise with synced sw[0]=1 -> guess_data<=synced sw[15:8], guess_valid<=1, go HOLD. btnC rise with sw[0]=0 is ignored.
  - HOLD: guess_valid=1 and guess_data frozen. On valid&ready -> guess_valid<=0, go ARMED. btnC rises in HOLD are dropped (no queue).
- Handshake:
  - guess_valid asserts one cycle after the btnC rise.
  - guess_valid never deasserts without ready.
  - ready sampled while valid=0 has no effect.
- new_num_pulse:
  - Equals btnU rise when started=1, in any non-IDLE state.
  - Does not cancel a pending guess in HOLD.
- attempt_cnt:
  - +1 on each valid&ready; saturates at 255.
  - Cleared to 0 on new_num_pulse.
  - new_num_pulse and handshake in the same cycle -> result 0 (clear wins).
- Simultaneous btnC and btnU rises are each handled independently in the same cycle.
- Reset mid-HOLD: guess_valid drops on the next edge, FSM=IDLE, started=0, so a fresh start press is required.

Optional Feature:
- Macro SW_DEBOUNCE_EN.
- When defined: sw[0] and sw[15:8] pass through the same debounce filter (one shared counter per bit group, reusing DEBOUNCE_CYCLES). Capture uses the debounced switch value.
- When undefined: switches are 2-flop synchronized only, capture uses synced values, and no extra counters are generated.
- Button behaviour is identical in both builds.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then hold btnC high 20 cycles -> start_pulse high exactly 1 cycle, 7 edges after btnC rise; started=1; guess_valid=0.
- Started, btnU glitch high 3 cycles then low -> no new_num_pulse. btnU held 10 cycles -> exactly one new_num_pulse; attempt_cnt=0.
- Started, sw=16'hA501, btnC press, guess_ready=0 for 10 cycles -> guess_valid=1, guess_data=8'hA5 held steady. Second btnC press during HOLD -> no change. Then ready=1 for one cycle -> valid=0, attempt_cnt=1.
- sw[0]=0, sw[15:8]=8'h3C, btnC press -> guess_valid stays 0, attempt_cnt unchanged.
- guess_ready tied 1, 257 submit presses -> attempt_cnt saturates at 255. Then a btnU press timed so new_num_pulse coincides with a handshake -> attempt_cnt=0.
- rst asserted while guess_valid=1 -> next edge: all outputs 0, started=0. btnU press afterwards -> no new_num_pulse until a btnC start.
